// File: rtl/jesd_lpbk_pkg.sv
// Shared types and constants for the JESD loopback ramp checker.
package jesd_lpbk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam int              LANE_W         = 16;
  localparam int              NUM_LANES      = 4;
  localparam logic [LANE_W-1:0] RAMP_STEP    = 16'd1;
  localparam int              LOCK_CNT_DEF   = 8;
  localparam int              UNLOCK_CNT_DEF = 4;

endpackage

// File: rtl/jesd_lpbk_checker_if.sv
// Lane sample bus from the loopback mux into the checker.
interface jesd_lpbk_checker_if;
  import jesd_lpbk_pkg::*;

  logic              din_valid;
  logic [LANE_W-1:0] adc_din_0;
  logic [LANE_W-1:0] adc_din_1;
  logic [LANE_W-1:0] adc_din_2;
  logic [LANE_W-1:0] adc_din_3;

  modport master (output din_valid, adc_din_0, adc_din_1, adc_din_2, adc_din_3);
  modport slave  (input  din_valid, adc_din_0, adc_din_1, adc_din_2, adc_din_3);

endinterface

// File: rtl/jesd_lpbk_lane_cmp.sv
// Stage 2: registered per-lane compare of stage-1 samples against E (even lanes) / ~E (odd lanes).
module jesd_lpbk_lane_cmp
  import jesd_lpbk_pkg::*;
(
  input  logic                              rx_link_clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              in_valid,
  input  logic [NUM_LANES-1:0][LANE_W-1:0]  lanes,
  input  logic [LANE_W-1:0]                 exp_e,
  output logic                              out_valid,
  output logic [NUM_LANES-1:0]              out_mis,
  output logic [LANE_W-1:0]                 out_lane0
);

  logic                 valid_q, valid_d;
  logic [NUM_LANES-1:0] mis_q, mis_d;
  logic [LANE_W-1:0]    lane0_q, lane0_d;

  always_comb begin
    valid_d = in_valid && !flush;
    lane0_d = lanes[0];
    mis_d   = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      mis_d[k] = (lanes[k] != (((k % 2) == 0) ? exp_e : ~exp_e));
    end
  end

  always_ff @(posedge rx_link_clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      mis_q   <= '0;
      lane0_q <= '0;
    end else begin
      valid_q <= valid_d;
      mis_q   <= mis_d;
      lane0_q <= lane0_d;
    end
  end

  assign out_valid = valid_q;
  assign out_mis   = mis_q;
  assign out_lane0 = lane0_q;

endmodule

// File: rtl/jesd_lpbk_checker.sv
// Loopback ramp checker: locks to the TX ramp, then counts samples/errors and flags bad lanes.
module jesd_lpbk_checker
  import jesd_lpbk_pkg::*;
#(
  parameter int LOCK_CNT   = LOCK_CNT_DEF,
  parameter int UNLOCK_CNT = UNLOCK_CNT_DEF,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  rx_link_clk,
  input  logic                  rst,
  input  logic                  check_en,
  input  logic                  clear,
  jesd_lpbk_checker_if.slave    rx,
  output logic                  locked,
  output logic                  lost_lock,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [CNT_WIDTH-1:0]  sample_cnt,
  output logic [NUM_LANES-1:0]  lane_err
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(UNLOCK_CNT + 1);

  state_e                           state_q, state_d;
  logic [LANE_W-1:0]                e_q, e_d, exp_e;
  logic                             seeded_q, seeded_d;
  logic [MATCH_W-1:0]               match_q, match_d, match_inc;
  logic [MISS_W-1:0]                miss_q, miss_d, miss_inc;
  logic                             locked_q, locked_d;
  logic                             lost_lock_q, lost_lock_d;
  logic [CNT_WIDTH-1:0]             err_q, err_d, smp_q, smp_d;
  logic [NUM_LANES-1:0]             lane_err_q, lane_err_d;
  logic                             s1_valid_q, s1_valid_d;
  logic [NUM_LANES-1:0][LANE_W-1:0] s1_lanes_q, s1_lanes_d;
  logic                             flush;
  logic                             s2_valid;
  logic [NUM_LANES-1:0]             s2_mis;
  logic [LANE_W-1:0]                s2_lane0;

  assign flush = !check_en || (state_q == IDLE);

  always_comb begin
    s1_valid_d = rx.din_valid && !flush;
    s1_lanes_d = {rx.adc_din_3, rx.adc_din_2, rx.adc_din_1, rx.adc_din_0};
  end

  // The stage-1 sample is judged against E as it will stand after the stage-2 sample
  // retires this edge, so back-to-back samples see the right (possibly reseeded) E.
  assign exp_e = e_d + RAMP_STEP;

  jesd_lpbk_lane_cmp u_lane_cmp (
    .rx_link_clk (rx_link_clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (s1_valid_q),
    .lanes       (s1_lanes_q),
    .exp_e       (exp_e),
    .out_valid   (s2_valid),
    .out_mis     (s2_mis),
    .out_lane0   (s2_lane0)
  );

  always_comb begin
    state_d     = state_q;
    e_d         = e_q;
    seeded_d    = seeded_q;
    match_d     = match_q;
    miss_d      = miss_q;
    lost_lock_d = 1'b0;
    err_d       = err_q;
    smp_d       = smp_q;
    lane_err_d  = lane_err_q;
    match_inc   = match_q + MATCH_W'(1);
    miss_inc    = miss_q + MISS_W'(1);

    if (!check_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = SEARCH;
          seeded_d = 1'b0;
          match_d  = '0;
          miss_d   = '0;
        end
        SEARCH: begin
          if (s2_valid) begin
            if (!seeded_q || (s2_mis != '0)) begin
              e_d      = s2_lane0;
              seeded_d = 1'b1;
              match_d  = '0;
            end else begin
              e_d     = e_q + RAMP_STEP;
              match_d = match_inc;
              if (match_inc == MATCH_W'(LOCK_CNT)) begin
                state_d = LOCKED;
                miss_d  = '0;
              end
            end
          end
        end
        LOCKED: begin
          if (s2_valid) begin
            e_d = e_q + RAMP_STEP;
            if (smp_q != '1) smp_d = smp_q + CNT_WIDTH'(1);
            if (s2_mis != '0) begin
              if (err_q != '1) err_d = err_q + CNT_WIDTH'(1);
              lane_err_d = lane_err_q | s2_mis;
              miss_d     = miss_inc;
              if (miss_inc == MISS_W'(UNLOCK_CNT)) begin
                state_d     = SEARCH;
                lost_lock_d = 1'b1;
                seeded_d    = 1'b0;
                match_d     = '0;
                miss_d      = '0;
              end
            end else begin
              miss_d = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (clear) begin
      err_d      = '0;
      smp_d      = '0;
      lane_err_d = '0;
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge rx_link_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      e_q         <= '0;
      seeded_q    <= 1'b0;
      match_q     <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      lost_lock_q <= 1'b0;
      err_q       <= '0;
      smp_q       <= '0;
      lane_err_q  <= '0;
      s1_valid_q  <= 1'b0;
      s1_lanes_q  <= '0;
    end else begin
      state_q     <= state_d;
      e_q         <= e_d;
      seeded_q    <= seeded_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      locked_q    <= locked_d;
      lost_lock_q <= lost_lock_d;
      err_q       <= err_d;
      smp_q       <= smp_d;
      lane_err_q  <= lane_err_d;
      s1_valid_q  <= s1_valid_d;
      s1_lanes_q  <= s1_lanes_d;
    end
  end

  assign locked     = locked_q;
  assign lost_lock  = lost_lock_q;
  assign err_cnt    = err_q;
  assign sample_cnt = smp_q;
  assign lane_err   = lane_err_q;

endmodule

// File: tb/tb_jesd_lpbk_checker.sv
// Directed bench for jesd_lpbk_checker (CNT_WIDTH=4 so saturation is reachable).
module tb_jesd_lpbk_checker;

  logic        clk;
  logic        rst;
  logic        check_en;
  logic        clear;
  logic        locked;
  logic        lost_lock;
  logic [3:0]  err_cnt;
  logic [3:0]  sample_cnt;
  logic [3:0]  lane_err;
  logic [15:0] e;
  int          tests;
  int          fails;

  jesd_lpbk_checker_if rx_if ();

  jesd_lpbk_checker #(
    .LOCK_CNT   (8),
    .UNLOCK_CNT (4),
    .CNT_WIDTH  (4)
  ) dut (
    .rx_link_clk (clk),
    .rst         (rst),
    .check_en    (check_en),
    .clear       (clear),
    .rx          (rx_if.slave),
    .locked      (locked),
    .lost_lock   (lost_lock),
    .err_cnt     (err_cnt),
    .sample_cnt  (sample_cnt),
    .lane_err    (lane_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle; valid samples follow the ramp, bad[k] flips a bit on lane k.
  task automatic send(input logic v, input logic [3:0] bad);
    rx_if.din_valid = v;
    if (v) begin
      rx_if.adc_din_0 = e  ^ (bad[0] ? 16'h0100 : 16'h0000);
      rx_if.adc_din_1 = ~e ^ (bad[1] ? 16'h0100 : 16'h0000);
      rx_if.adc_din_2 = e  ^ (bad[2] ? 16'h0100 : 16'h0000);
      rx_if.adc_din_3 = ~e ^ (bad[3] ? 16'h0100 : 16'h0000);
      e = e + 16'd1;
    end else begin
      rx_if.adc_din_0 = 16'hDEAD;
      rx_if.adc_din_1 = 16'hDEAD;
      rx_if.adc_din_2 = 16'hDEAD;
      rx_if.adc_din_3 = 16'hDEAD;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 4'b0000);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    e = 16'h0000;
    rst = 1'b1;
    check_en = 1'b0;
    clear = 1'b0;
    idle(3);
    chk("rst_locked", locked, 0);
    chk("rst_lost", lost_lock, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_smp", sample_cnt, 0);
    chk("rst_lane_err", lane_err, 0);

    // Initial lock on a continuous ramp from 0x0010
    rst = 1'b0;
    check_en = 1'b1;
    idle(1);
    e = 16'h0010;
    for (int i = 0; i < 8; i++) send(1'b1, 4'b0000);
    chk("lock_after8", locked, 0);
    send(1'b1, 4'b0000);
    chk("lock_k", locked, 0);
    send(1'b1, 4'b0000);
    chk("lock_k1", locked, 0);
    send(1'b1, 4'b0000);
    chk("lock_k2", locked, 1);
    chk("lock_smp0", sample_cnt, 0);
    send(1'b1, 4'b0000);
    idle(2);
    chk("lock_smp3", sample_cnt, 3);
    chk("lock_err0", err_cnt, 0);
    chk("lock_lane0", lane_err, 0);

    // check_en drop, relock near the 16-bit wrap
    check_en = 1'b0;
    send(1'b0, 4'b0000);
    chk("dis_locked", locked, 0);
    chk("dis_lost", lost_lock, 0);
    check_en = 1'b1;
    idle(1);
    e = 16'hFFF5;
    for (int i = 0; i < 13; i++) send(1'b1, 4'b0000);
    idle(2);
    chk("wrap_locked", locked, 1);
    chk("wrap_err", err_cnt, 0);
    chk("wrap_smp", sample_cnt, 7);

    // Sparse lane-2 corruption
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    chk("clr_smp", sample_cnt, 0);
    chk("clr_err", err_cnt, 0);
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 4'b0000);
      send(1'b1, 4'b0100);
    end
    send(1'b1, 4'b0000);
    idle(2);
    chk("l2_err", err_cnt, 3);
    chk("l2_lane", lane_err, 4'b0100);
    chk("l2_locked", locked, 1);
    chk("l2_smp", sample_cnt, 7);

    // Four consecutive misses drop lock, then relock
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b1, 4'b0001);
    chk("miss_still", locked, 1);
    send(1'b1, 4'b0000);
    chk("miss_a4_locked", locked, 1);
    chk("miss_a4_lost", lost_lock, 0);
    send(1'b1, 4'b0000);
    chk("miss_drop_locked", locked, 0);
    chk("miss_drop_lost", lost_lock, 1);
    chk("miss_drop_err", err_cnt, 4);
    send(1'b1, 4'b0000);
    chk("miss_pulse_end", lost_lock, 0);
    for (int i = 0; i < 6; i++) send(1'b1, 4'b0000);
    send(1'b1, 4'b0000);
    chk("relock_k1", locked, 0);
    send(1'b1, 4'b0000);
    chk("relock_k2", locked, 1);
    idle(2);
    chk("relock_smp", sample_cnt, 6);
    chk("relock_err", err_cnt, 4);
    chk("relock_lane", lane_err, 4'b0001);

    // Saturation at 4'hF
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    for (int i = 0; i < 17; i++) begin
      send(1'b1, 4'b1000);
      send(1'b1, 4'b0000);
    end
    idle(2);
    chk("sat_err", err_cnt, 4'hF);
    chk("sat_smp", sample_cnt, 4'hF);
    chk("sat_lane", lane_err, 4'b1000);
    chk("sat_locked", locked, 1);

    // clear on the same edge as an error increment
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    send(1'b1, 4'b0010);
    send(1'b1, 4'b0000);
    clear = 1'b1;
    send(1'b1, 4'b0000);
    clear = 1'b0;
    chk("clrinc_err", err_cnt, 0);
    chk("clrinc_smp", sample_cnt, 0);
    chk("clrinc_lane", lane_err, 0);
    chk("clrinc_locked", locked, 1);
    idle(2);
    chk("clrinc_smp2", sample_cnt, 2);
    chk("clrinc_err2", err_cnt, 0);

    // Lock with din_valid gaps between samples
    check_en = 1'b0;
    idle(1);
    check_en = 1'b1;
    idle(1);
    e = 16'h1234;
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 4'b0000);
      send(1'b0, 4'b0000);
    end
    send(1'b1, 4'b0000);
    chk("gap_k", locked, 0);
    send(1'b0, 4'b0000);
    chk("gap_k1", locked, 0);
    send(1'b0, 4'b0000);
    chk("gap_k2", locked, 1);
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 4'b0000);
      send(1'b0, 4'b0000);
    end
    idle(2);
    chk("gap_err", err_cnt, 0);
    chk("gap_smp", sample_cnt, 5);
    chk("gap_lane", lane_err, 0);

    // Reset while locked
    rst = 1'b1;
    send(1'b0, 4'b0000);
    chk("rstlk_locked", locked, 0);
    chk("rstlk_lost", lost_lock, 0);
    chk("rstlk_smp", sample_cnt, 0);
    rst = 1'b0;
    idle(1);
    chk("rstlk_lost2", lost_lock, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
